// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: circular buffer of {pc, ir} with valid/ready handshake.
// Optional IFQ_STATS_EN adds stall_cnt / flush_cnt statistic counters.
module if_id_queue #(
   parameter int DEPTH = 2,
   parameter int IR_W  = 32,
   parameter int PC_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   if_valid,
   output logic                   if_ready,
   input  logic [PC_W-1:0]        if_pc,
   input  logic [IR_W-1:0]        if_ir,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [PC_W-1:0]        id_pc,
   output logic [IR_W-1:0]        id_ir,
   output logic [$clog2(DEPTH):0] count
`ifdef IFQ_STATS_EN
   ,
   output logic [31:0]            stall_cnt,
   output logic [15:0]            flush_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PC_W + IR_W;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   assign if_ready = (count != CW'(DEPTH));
   assign id_valid = (count != '0);
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & id_ready;
   assign head     = mem[rd_ptr];
   assign id_pc    = id_valid ? head[EW-1:IR_W] : '0;
   assign id_ir    = id_valid ? head[IR_W-1:0] : '0;

   // Entry contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= {if_pc, if_ir};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

`ifdef IFQ_STATS_EN
   // Both counters saturate rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (id_valid && !id_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= CW'(DEPTH))
            else $error("if_id_queue occupancy above DEPTH");
      end
   end
`endif

endmodule
